// File: rtl/segway_math_pipe_if.sv
// rtl/segway_math_pipe_if.sv - sample/command bundle between PID source, balance math and motor drive
interface segway_math_pipe_if #(
  parameter int W    = 12,
  parameter int SS_W = 8
);
  logic                vld_in;
  logic signed [W-1:0] PID_cntrl;
  logic [11:0]         steer_pot;
  logic                en_steer;
  logic                pwr_up;
  logic                vld_out;
  logic signed [W-1:0] lft_spd;
  logic signed [W-1:0] rght_spd;
  logic                too_fast;
  logic [SS_W-1:0]     ss_tmr;

  modport master (
    output vld_in, PID_cntrl, steer_pot, en_steer, pwr_up,
    input  vld_out, lft_spd, rght_spd, too_fast, ss_tmr
  );

  modport slave (
    input  vld_in, PID_cntrl, steer_pot, en_steer, pwr_up,
    output vld_out, lft_spd, rght_spd, too_fast, ss_tmr
  );
endinterface

// File: rtl/segway_math_pipe.sv
// rtl/segway_math_pipe.sv - 3-stage Segway balance math (soft-start, steer, deadzone, saturate); SEGMATH_SLEW_EN adds output slew limit
module segway_math_pipe #(
  parameter int          W           = 12,
  parameter int          SS_W        = 8,
  parameter int          SS_STEP     = 1,
  parameter logic [11:0] STEER_MIN   = 12'h200,
  parameter logic [11:0] STEER_MAX   = 12'hE00,
  parameter logic [11:0] MIN_DUTY    = 12'h3C0,
  parameter logic [7:0]  LOW_BAND    = 8'h3C,
  parameter int          GAIN_MULT   = 4,
  parameter int          FAST_THRESH = 1536,
  parameter int          FAST_CNT    = 4,
  parameter int          SLEW        = 64
) (
  input logic               clk,
  input logic               rst_n,
  segway_math_pipe_if.slave bus
);
  localparam int PW = W + SS_W + 1;
  localparam int TW = W + 2;
  localparam int SW = W + 5;
  localparam int CW = $clog2(FAST_CNT + 1);
  localparam logic [SS_W-1:0]        SS_MAX   = '1;
  localparam logic [SS_W-1:0]        SS_INC   = SS_W'(SS_STEP);
  localparam logic signed [SW-1:0]   DUTY_S   = SW'(MIN_DUTY);
  localparam logic [SW-1:0]          BAND_U   = SW'(LOW_BAND);
  localparam logic signed [SW-1:0]   GAIN_S   = SW'(GAIN_MULT);
  localparam logic signed [SW-1:0]   SAT_HI   = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0]   SAT_LO   = ~SAT_HI;
  localparam logic [W-1:0]           THRESH_U = W'(FAST_THRESH);
  localparam logic [CW-1:0]          CNT_MAX  = CW'(FAST_CNT);

  // low band gets a gain boost, everything else jumps past the motor deadzone
  function automatic logic signed [SW-1:0] shape(input logic signed [TW-1:0] t);
    logic signed [SW-1:0] te;
    logic [SW-1:0]        mag;
    te  = $signed({{(SW-TW){t[TW-1]}}, t});
    mag = te[SW-1] ? -te : te;
    if (te == '0)          shape = '0;
    else if (mag < BAND_U) shape = te * GAIN_S;
    else if (te[SW-1])     shape = te - DUTY_S;
    else                   shape = te + DUTY_S;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      sat = SAT_HI[W-1:0];
    else if (v < SAT_LO) sat = SAT_LO[W-1:0];
    else                 sat = v[W-1:0];
  endfunction

`ifdef SEGMATH_SLEW_EN
  function automatic logic signed [W-1:0] slew_lim(input logic signed [W-1:0] tgt,
                                                   input logic signed [W-1:0] prev);
    logic signed [W+1:0] d;
    logic signed [W+1:0] step;
    d    = $signed({{2{tgt[W-1]}}, tgt}) - $signed({{2{prev[W-1]}}, prev});
    step = (W + 2)'(SLEW);
    if (d > step)       slew_lim = prev + W'(SLEW);
    else if (d < -step) slew_lim = prev - W'(SLEW);
    else                slew_lim = tgt;
  endfunction
`endif

  logic [11:0]          steer_c;
  logic signed [15:0]   steer_d, steer_x3, steer_sc;
  logic signed [PW-1:0] pid_prod, pid_shift;

  // stage 1 arithmetic: steer clip/centre/scale and soft-start scaling of the PID term
  always_comb begin
    if (bus.steer_pot < STEER_MIN)      steer_c = STEER_MIN;
    else if (bus.steer_pot > STEER_MAX) steer_c = STEER_MAX;
    else                                steer_c = bus.steer_pot;
    steer_d   = $signed({4'b0000, steer_c}) - 16'sd2047;
    steer_x3  = steer_d * 16'sd3;
    steer_sc  = steer_x3 >>> 4;
    pid_prod  = bus.PID_cntrl * $signed({1'b0, bus.ss_tmr});
    pid_shift = pid_prod >>> SS_W;
  end

  // soft-start ramp: one step per accepted powered sample, cleared whenever power is off
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.pwr_up)         bus.ss_tmr <= '0;
    else if (bus.vld_in) begin
      if (bus.ss_tmr > SS_MAX - SS_INC) bus.ss_tmr <= SS_MAX;
      else                              bus.ss_tmr <= bus.ss_tmr + SS_INC;
    end
  end

  logic                s1_vld, s1_pwr, s1_en;
  logic signed [W-1:0] s1_pid;
  logic signed [11:0]  s1_steer;

  // stage 1 register: capture scaled terms alongside the sample's power state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_pwr   <= 1'b0;
      s1_en    <= 1'b0;
      s1_pid   <= '0;
      s1_steer <= '0;
    end else begin
      s1_vld <= bus.vld_in;
      if (bus.vld_in) begin
        s1_pwr   <= bus.pwr_up;
        s1_en    <= bus.en_steer;
        s1_pid   <= pid_shift[W-1:0];
        s1_steer <= steer_sc[11:0];
      end
    end
  end

  logic signed [TW-1:0] steer_t, lft_sum, rght_sum;

  // stage 2 arithmetic: differential steer mix, widened so it cannot wrap
  always_comb begin
    steer_t  = s1_en ? $signed({{(TW-12){s1_steer[11]}}, s1_steer}) : '0;
    lft_sum  = $signed({{2{s1_pid[W-1]}}, s1_pid}) + steer_t;
    rght_sum = $signed({{2{s1_pid[W-1]}}, s1_pid}) - steer_t;
  end

  logic                 s2_vld, s2_pwr;
  logic signed [SW-1:0] s2_lft, s2_rght;

  // stage 2 register: deadzone-shaped wheel commands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_pwr  <= 1'b0;
      s2_lft  <= '0;
      s2_rght <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_pwr  <= s1_pwr;
        s2_lft  <= shape(lft_sum);
        s2_rght <= shape(rght_sum);
      end
    end
  end

  logic signed [W-1:0] lft_nxt, rght_nxt;
  logic [W-1:0]        lft_mag, rght_mag;
  logic                fast;
  logic [CW-1:0]       fast_cnt, cnt_nxt;

  // stage 3 arithmetic: saturate, force zero when unpowered, then judge over-speed on the new values
  always_comb begin
`ifdef SEGMATH_SLEW_EN
    lft_nxt  = s2_pwr ? slew_lim(sat(s2_lft), bus.lft_spd)   : '0;
    rght_nxt = s2_pwr ? slew_lim(sat(s2_rght), bus.rght_spd) : '0;
`else
    lft_nxt  = s2_pwr ? sat(s2_lft)  : '0;
    rght_nxt = s2_pwr ? sat(s2_rght) : '0;
`endif
    lft_mag  = lft_nxt[W-1]  ? -lft_nxt  : lft_nxt;
    rght_mag = rght_nxt[W-1] ? -rght_nxt : rght_nxt;
    fast     = (lft_mag > THRESH_U) || (rght_mag > THRESH_U);
    if (!fast)                    cnt_nxt = '0;
    else if (fast_cnt == CNT_MAX) cnt_nxt = CNT_MAX;
    else                          cnt_nxt = fast_cnt + 1'b1;
  end

  // stage 3 register: outputs and over-speed run counter move together on each valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.vld_out  <= 1'b0;
      bus.lft_spd  <= '0;
      bus.rght_spd <= '0;
      bus.too_fast <= 1'b0;
      fast_cnt     <= '0;
    end else begin
      bus.vld_out <= s2_vld;
      if (s2_vld) begin
        bus.lft_spd  <= lft_nxt;
        bus.rght_spd <= rght_nxt;
        bus.too_fast <= (cnt_nxt == CNT_MAX);
        fast_cnt     <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_segway_math_pipe.sv
// tb/tb_segway_math_pipe.sv - randomized bench with behavioural model for segway_math_pipe
module tb_segway_math_pipe;
  localparam int W    = 12;
  localparam int SS_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  segway_math_pipe_if #(.W(W), .SS_W(SS_W)) bus ();
  segway_math_pipe #(.W(W), .SS_W(SS_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int due;
    int l;
    int r;
    bit pw;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   m_l = 0, m_r = 0, m_cnt = 0, m_ss = 0;
  bit   m_tf = 0;
  bit   chk_en = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int shape_m(int t);
    if (t == 0) return 0;
    if (iabs(t) < 60) return t * 4;
    return (t > 0) ? t + 960 : t - 960;
  endfunction

  function automatic int sat_m(int v);
    return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
  endfunction

  function automatic int lim_m(int tgt, int prev);
    return (tgt > prev + 64) ? prev + 64 : ((tgt < prev - 64) ? prev - 64 : tgt);
  endfunction

  // wheel commands as the balance equations define them, ignoring power state
  task automatic model(input int pid, input int steer, input bit en, input int ss,
                       output int l, output int r);
    int pid_ss, sc, ssc;
    pid_ss = (pid * ss) >>> 8;
    sc     = (steer < 512) ? 512 : ((steer > 3584) ? 3584 : steer);
    ssc    = en ? (((sc - 2047) * 3) >>> 4) : 0;
    l      = sat_m(shape_m(pid_ss + ssc));
    r      = sat_m(shape_m(pid_ss - ssc));
  endtask

  // compare process: expected output stream, hold behaviour, over-speed flag and ss_tmr every cycle
  always @(negedge clk) begin : cmp
    exp_t e;
    bit   due, fast;
    if (chk_en) begin
      due = (q.size() > 0) && (q[0].due == cyc);
      check("vld_out", bus.vld_out, int'(due));
      if (due) begin
        e = q.pop_front();
`ifdef SEGMATH_SLEW_EN
        m_l = e.pw ? lim_m(e.l, m_l) : 0;
        m_r = e.pw ? lim_m(e.r, m_r) : 0;
`else
        m_l = e.pw ? e.l : 0;
        m_r = e.pw ? e.r : 0;
`endif
        fast  = (iabs(m_l) > 1536) || (iabs(m_r) > 1536);
        m_cnt = fast ? ((m_cnt < 4) ? m_cnt + 1 : 4) : 0;
        m_tf  = (m_cnt == 4);
      end
      check("lft_spd", $signed(bus.lft_spd), m_l);
      check("rght_spd", $signed(bus.rght_spd), m_r);
      check("too_fast", bus.too_fast, int'(m_tf));
      check("ss_tmr", bus.ss_tmr, m_ss);
    end
  end

  // one clock of stimulus; model ss_tmr follows the capture edge
  task automatic cycle(input bit v, input bit pw, input bit en, input int pid, input int steer);
    exp_t e;
    int   l, r;
    bus.vld_in    = v;
    bus.pwr_up    = pw;
    bus.en_steer  = en;
    bus.PID_cntrl = pid[W-1:0];
    bus.steer_pot = steer[11:0];
    if (v) begin
      model(pid, steer, en, m_ss, l, r);
      e.due = cyc + 3;
      e.l   = l;
      e.r   = r;
      e.pw  = pw;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!pw)    m_ss = 0;
    else if (v) m_ss = (m_ss < 255) ? m_ss + 1 : 255;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b1, 1'b1, 0, 12'h7FF);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.vld_in    = 1'b0;
    bus.pwr_up    = 1'b0;
    bus.en_steer  = 1'b0;
    bus.PID_cntrl = '0;
    bus.steer_pot = '0;
    @(posedge clk);
    #1;
    q.delete();
    m_l = 0; m_r = 0; m_cnt = 0; m_tf = 0; m_ss = 0;
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    int l, r, pid, steer;
    bit v, pw, en;

    model(256, 12'h7FF, 1'b1, 255, l, r);
    check("pin_centre_l", l, 1215);
    check("pin_centre_r", r, 1215);
    model(256, 12'hFFF, 1'b1, 255, l, r);
    check("pin_clip_l", l, 1503);
    check("pin_clip_r", r, -132);
    model(-256, 12'h7FF, 1'b1, 255, l, r);
    check("pin_neg_l", l, -1215);
    model(2047, 12'h7FF, 1'b1, 255, l, r);
    check("pin_sat_l", l, 2047);

    do_reset();
    check("rst_lft", $signed(bus.lft_spd), 0);
    check("rst_vld", bus.vld_out, 0);
    check("rst_tf", bus.too_fast, 0);
    check("rst_ss", bus.ss_tmr, 0);

    for (int i = 0; i < 260; i++)
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048,
            int'($urandom_range(0, 4095)));
    check("ss_saturated", bus.ss_tmr, 255);

`ifndef SEGMATH_SLEW_EN
    cycle(1'b1, 1'b1, 1'b1, 256, 12'h7FF);
    idle(3);
    check("case1_l", $signed(bus.lft_spd), 1215);
    check("case1_r", $signed(bus.rght_spd), 1215);
    cycle(1'b1, 1'b1, 1'b1, 256, 12'hFFF);
    cycle(1'b1, 1'b1, 1'b0, 256, 12'hFFF);
    idle(1);
    check("case2_l", $signed(bus.lft_spd), 1503);
    check("case2_r", $signed(bus.rght_spd), -132);
    idle(1);
    check("case2_noen", $signed(bus.rght_spd), 1215);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 2047, 12'h7FF);
    idle(3);
    check("case3_sat", $signed(bus.lft_spd), 2047);
    check("case3_tf", bus.too_fast, 1);
    cycle(1'b1, 1'b1, 1'b1, 256, 12'h7FF);
    idle(3);
    check("case3_clear", bus.too_fast, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      pw = ($urandom_range(0, 511) != 0);
      en = 1'($urandom_range(0, 1));
      pid = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 2047 : -2048)
                                        : int'($urandom_range(0, 4095)) - 2048;
      steer = int'($urandom_range(0, 4095));
      cycle(v, pw, en, pid, steer);
    end

    cycle(1'b0, 1'b0, 1'b1, 0, 12'h7FF);
    check("pwr_off_ss", bus.ss_tmr, 0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'b1, 1024, 12'h7FF);
    check("ramp_hold", bus.ss_tmr, 255);
    cycle(1'b1, 1'b0, 1'b1, 1024, 12'h7FF);
    check("drop_ss", bus.ss_tmr, 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 0, 12'h7FF);
    check("drop_out", $signed(bus.lft_spd), 0);

    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 2047, 12'h9FF);
    cycle(1'b1, 1'b1, 1'b1, 2047, 12'h9FF);
    cycle(1'b1, 1'b1, 1'b1, 2047, 12'h9FF);
    do_reset();
    check("flush_l", $signed(bus.lft_spd), 0);
    check("flush_ss", bus.ss_tmr, 0);
    idle(4);
    check("flush_vld", bus.vld_out, 0);

    idle(4);
    check("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
